irig_b_frame_sched: RTL and testbench

//  Frame scheduler for the IRIG-B time-code path. Builds the 100-symbol IRIG-B frame (P / 1 / 0)

---
 rtl/irig_b_pkg.sv | 45 ++++
 rtl/irig_b_tod_inc.sv | 61 ++++++
 rtl/irig_b_frame_sched.sv | 120 ++++++++++++
 tb/tb_irig_b_frame_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/irig_b_pkg.sv
// Shared types and frame-map constants for the IRIG-B frame scheduler.
package irig_b_pkg;

  localparam int FRAME_LEN_DEF = 100;
  localparam int DAY_MAX_DEF   = 365;

  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_ONE  = 2'b01,
    SYM_P    = 2'b10
  } sym_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  typedef struct packed {
    logic [9:0] day;
    logic [5:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
  } tod_t;

  localparam tod_t TOD_RESET = '{day: 10'h001, hour: 6'h00, min: 7'h00, sec: 7'h00};

  // Position markers at 0 and every index ending in 9.
  localparam logic [99:0] P_MASK = 100'h80200_80200_80200_80200_80201;

  localparam int SEC_U_IDX  = 1;
  localparam int SEC_T_IDX  = 6;
  localparam int MIN_U_IDX  = 10;
  localparam int MIN_T_IDX  = 15;
  localparam int HOUR_U_IDX = 20;
  localparam int HOUR_T_IDX = 25;
  localparam int DAY_U_IDX  = 30;
  localparam int DAY_T_IDX  = 35;
  localparam int DAY_H_IDX  = 40;

  function automatic logic [9:0] day_bin(input logic [9:0] d);
    return 10'(d[9:8]) * 10'd100 + 10'(d[7:4]) * 10'd10 + 10'(d[3:0]);
  endfunction

endpackage

// File: rtl/irig_b_tod_inc.sv
// BCD one-second incrementer for the time-of-day record, registered, with day-of-year wrap.
module irig_b_tod_inc
  import irig_b_pkg::*;
#(
  parameter int DAY_MAX = DAY_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  tod_t tod_in,
  output tod_t tod_next
);

  localparam logic [9:0] DAY_MAX_B = 10'(DAY_MAX);

  // Returns {carry, next} for a 00..59 BCD field.
  function automatic logic [7:0] inc60(input logic [6:0] v);
    if (v[3:0] != 4'd9) return {1'b0, v[6:4], v[3:0] + 4'd1};
    if (v[6:4] != 3'd5) return {1'b0, v[6:4] + 3'd1, 4'd0};
    return 8'h80;
  endfunction

  tod_t inc_p0;
  logic c_min, c_hour, c_day;

  always_comb begin
    inc_p0 = tod_in;
    c_min  = 1'b0;
    c_hour = 1'b0;
    c_day  = 1'b0;
    {c_min, inc_p0.sec} = inc60(tod_in.sec);
    if (c_min) {c_hour, inc_p0.min} = inc60(tod_in.min);
    if (c_hour) begin
      if (tod_in.hour == 6'h23) begin
        inc_p0.hour = 6'h00;
        c_day       = 1'b1;
      end else if (tod_in.hour[3:0] == 4'd9) begin
        inc_p0.hour = {tod_in.hour[5:4] + 2'd1, 4'd0};
      end else begin
        inc_p0.hour[3:0] = tod_in.hour[3:0] + 4'd1;
      end
    end
    if (c_day) begin
      if (day_bin(tod_in.day) >= DAY_MAX_B) begin
        inc_p0.day = 10'h001;
      end else if (tod_in.day[3:0] != 4'd9) begin
        inc_p0.day[3:0] = tod_in.day[3:0] + 4'd1;
      end else if (tod_in.day[7:4] != 4'd9) begin
        inc_p0.day[7:0] = {tod_in.day[7:4] + 4'd1, 4'd0};
      end else begin
        inc_p0.day = {tod_in.day[9:8] + 2'd1, 8'h00};
      end
    end
  end

  // p0 -> p1: registered next-second value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tod_next <= TOD_RESET;
    else        tod_next <= inc_p0;
  end

endmodule

// File: rtl/irig_b_frame_sched.sv
// IRIG-B frame scheduler: builds the 100-symbol frame from live BCD time and streams it over valid/ready.
// Optional TOD_AUTO_INC_EN: pending time advances by one second at each frame end.
module irig_b_frame_sched
  import irig_b_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DAY_MAX   = DAY_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       tod_load,
  input  logic [6:0] sec_bcd,
  input  logic [6:0] min_bcd,
  input  logic [5:0] hour_bcd,
  input  logic [9:0] day_bcd,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [1:0] sym_code,
  output logic [6:0] sym_index,
  output logic       frame_done,
  output logic       busy,
  output logic       tod_err
);

  localparam logic [6:0] LAST_IDX  = 7'(FRAME_LEN - 1);
  localparam logic [9:0] DAY_MAX_B = 10'(DAY_MAX);

  function automatic logic tod_valid(input tod_t t);
    logic [9:0] d;
    d = day_bin(t.day);
    return (t.sec[3:0] <= 4'd9) && (t.sec[6:4] <= 3'd5) &&
           (t.min[3:0] <= 4'd9) && (t.min[6:4] <= 3'd5) &&
           (t.hour[3:0] <= 4'd9) && (t.hour[5:4] <= 2'd2) &&
           !((t.hour[5:4] == 2'd2) && (t.hour[3:0] > 4'd3)) &&
           (t.day[3:0] <= 4'd9) && (t.day[7:4] <= 4'd9) &&
           (d != 10'd0) && (d <= DAY_MAX_B);
  endfunction

  state_t      state;
  logic [6:0]  index;
  tod_t        active, pending, load_val;
  logic [99:0] frame_bits;
  logic        load_ok, load_bad, hs_last;

  assign load_val = '{day: day_bcd, hour: hour_bcd, min: min_bcd, sec: sec_bcd};
  assign load_ok  = tod_load & tod_valid(load_val);
  assign load_bad = tod_load & ~tod_valid(load_val);
  assign hs_last  = (state == ST_SEND) & sym_ready & (index == LAST_IDX);

`ifdef TOD_AUTO_INC_EN
  tod_t tod_next;

  irig_b_tod_inc #(.DAY_MAX(DAY_MAX)) u_tod_inc (
    .clk      (clk),
    .rst_n    (rst_n),
    .tod_in   (active),
    .tod_next (tod_next)
  );
`endif

  // BCD fields are sent LSB first at their fixed frame positions.
  always_comb begin
    frame_bits                   = '0;
    frame_bits[SEC_U_IDX  +: 4]  = active.sec[3:0];
    frame_bits[SEC_T_IDX  +: 3]  = active.sec[6:4];
    frame_bits[MIN_U_IDX  +: 4]  = active.min[3:0];
    frame_bits[MIN_T_IDX  +: 3]  = active.min[6:4];
    frame_bits[HOUR_U_IDX +: 4]  = active.hour[3:0];
    frame_bits[HOUR_T_IDX +: 2]  = active.hour[5:4];
    frame_bits[DAY_U_IDX  +: 4]  = active.day[3:0];
    frame_bits[DAY_T_IDX  +: 4]  = active.day[7:4];
    frame_bits[DAY_H_IDX  +: 2]  = active.day[9:8];
  end

  assign sym_valid = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);
  assign sym_index = index;
  assign sym_code  = !sym_valid      ? SYM_ZERO :
                     P_MASK[index]   ? SYM_P    :
                     frame_bits[index] ? SYM_ONE : SYM_ZERO;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      index      <= '0;
      active     <= TOD_RESET;
      pending    <= TOD_RESET;
      frame_done <= 1'b0;
      tod_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      tod_err    <= load_bad;
      if (load_ok) pending <= load_val;
`ifdef TOD_AUTO_INC_EN
      else if (hs_last) pending <= tod_next;
`endif
      case (state)
        ST_IDLE: if (run) state <= ST_LATCH;
        ST_LATCH: begin
          // A load arriving in this very cycle is bypassed straight into the frame.
          active <= load_ok ? load_val : pending;
          index  <= '0;
          state  <= ST_SEND;
        end
        ST_SEND: begin
          if (hs_last) begin
            frame_done <= 1'b1;
            index      <= '0;
            state      <= run ? ST_LATCH : ST_IDLE;
          end else if (sym_ready) begin
            index <= index + 7'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irig_b_frame_sched.sv
// Directed bench for irig_b_frame_sched: frame map, stall, mid-frame load, bypass, run drop, reset.
module tb_irig_b_frame_sched;

  logic       clk = 1'b0;
  logic       rst_n, run, tod_load, sym_ready;
  logic [6:0] sec_bcd, min_bcd;
  logic [5:0] hour_bcd;
  logic [9:0] day_bcd;
  logic       sym_valid, frame_done, busy, tod_err;
  logic [1:0] sym_code;
  logic [6:0] sym_index;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected times, packed {day, hour, min, sec}
  localparam logic [29:0] TOD_A = {10'h123, 6'h12, 7'h34, 7'h56};
  localparam logic [29:0] TOD_E = {10'h045, 6'h01, 7'h02, 7'h03};
  localparam logic [29:0] TOD_F = {10'h365, 6'h23, 7'h59, 7'h59};
`ifdef TOD_AUTO_INC_EN
  localparam logic [29:0] TOD_B = {10'h123, 6'h12, 7'h34, 7'h57};
  localparam logic [29:0] TOD_C = {10'h123, 6'h12, 7'h34, 7'h58};
  localparam logic [29:0] TOD_D = {10'h123, 6'h12, 7'h34, 7'h59};
  localparam logic [29:0] TOD_G = {10'h001, 6'h00, 7'h00, 7'h00};
`else
  localparam logic [29:0] TOD_B = TOD_A;
  localparam logic [29:0] TOD_C = {10'h001, 6'h00, 7'h00, 7'h01};
  localparam logic [29:0] TOD_D = TOD_C;
  localparam logic [29:0] TOD_G = TOD_F;
`endif

  irig_b_frame_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .tod_load   (tod_load),
    .sec_bcd    (sec_bcd),
    .min_bcd    (min_bcd),
    .hour_bcd   (hour_bcd),
    .day_bcd    (day_bcd),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_code   (sym_code),
    .sym_index  (sym_index),
    .frame_done (frame_done),
    .busy       (busy),
    .tod_err    (tod_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Independent frame map: 2 = P, 1 = one, 0 = zero.
  function automatic int exp_code(input logic [29:0] t, input int i);
    int v, pos;
    if (i == 0 || (i % 10) == 9) return 2;
    v = -1;
    pos = 0;
    if      (i >= 1  && i <= 4)  begin v = int'(t[6:0]);   pos = i - 1;      end
    else if (i >= 6  && i <= 8)  begin v = int'(t[6:0]);   pos = i - 6 + 4;  end
    else if (i >= 10 && i <= 13) begin v = int'(t[13:7]);  pos = i - 10;     end
    else if (i >= 15 && i <= 17) begin v = int'(t[13:7]);  pos = i - 15 + 4; end
    else if (i >= 20 && i <= 23) begin v = int'(t[19:14]); pos = i - 20;     end
    else if (i >= 25 && i <= 26) begin v = int'(t[19:14]); pos = i - 25 + 4; end
    else if (i >= 30 && i <= 33) begin v = int'(t[29:20]); pos = i - 30;     end
    else if (i >= 35 && i <= 38) begin v = int'(t[29:20]); pos = i - 35 + 4; end
    else if (i >= 40 && i <= 41) begin v = int'(t[29:20]); pos = i - 40 + 8; end
    if (v < 0) return 0;
    return (v >> pos) & 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tod(input logic [29:0] t);
    {day_bcd, hour_bcd, min_bcd, sec_bcd} = t;
    tod_load = 1'b1;
    step();
    tod_load = 1'b0;
  endtask

  // Streams one frame with sym_ready high, checking every symbol; optional events at given indices.
  task automatic capture(input string nm, input logic [29:0] t, input int stall_idx,
                         input int ld_idx, input int drop_idx, input int rst_idx);
    int w = 0;
    while (!sym_valid && w < 20) begin
      step();
      w++;
    end
    check({nm, "_start"}, sym_valid, 1);
    for (int i = 0; i < 100; i++) begin
      check({nm, "_idx"}, sym_index, i);
      check({nm, "_code"}, sym_code, exp_code(t, i));
      if (i == rst_idx) begin
        rst_n = 1'b0;
        #1;
        check({nm, "_rst_valid"}, sym_valid, 0);
        check({nm, "_rst_busy"}, busy, 0);
        check({nm, "_rst_idx"}, sym_index, 0);
        #1;
        rst_n = 1'b1;
        return;
      end
      if (i == stall_idx) begin
        sym_ready = 1'b0;
        repeat (50) begin
          step();
          check({nm, "_stall_valid"}, sym_valid, 1);
          check({nm, "_stall_idx"}, sym_index, i);
          check({nm, "_stall_code"}, sym_code, exp_code(t, i));
        end
        sym_ready = 1'b1;
      end
      if (i == ld_idx) begin
        {day_bcd, hour_bcd, min_bcd, sec_bcd} = {10'h001, 6'h00, 7'h00, 7'h01};
        tod_load = 1'b1;
      end
      if (i == drop_idx) run = 1'b0;
      step();
      tod_load = 1'b0;
    end
    check({nm, "_frame_done"}, frame_done, 1);
    if (drop_idx >= 0) begin
      check({nm, "_end_busy"}, busy, 0);
      check({nm, "_end_valid"}, sym_valid, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; tod_load = 1'b0; sym_ready = 1'b0;
    sec_bcd = '0; min_bcd = '0; hour_bcd = '0; day_bcd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", sym_valid, 0);
    check("rst_code", sym_code, 0);
    check("rst_index", sym_index, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_tod_err", tod_err, 0);
    rst_n = 1'b1;
    step();

    load_tod(TOD_A);
    check("load_a_err", tod_err, 0);
    run = 1'b1;
    sym_ready = 1'b1;
    capture("A", TOD_A, 5, -1, -1, -1);
    capture("B", TOD_B, -1, 40, -1, -1);
    capture("C", TOD_C, -1, -1, 50, -1);
    step();
    check("fd_pulse_len", frame_done, 0);
    check("idle_busy", busy, 0);

    load_tod({10'h001, 6'h00, 7'h00, 7'h5A});
    check("bad_sec_err", tod_err, 1);
    step();
    check("err_pulse_len", tod_err, 0);
    load_tod({10'h001, 6'h24, 7'h00, 7'h00});
    check("bad_hour_err", tod_err, 1);
    load_tod({10'h366, 6'h00, 7'h00, 7'h00});
    check("bad_day_hi_err", tod_err, 1);
    load_tod({10'h000, 6'h00, 7'h00, 7'h00});
    check("bad_day_zero_err", tod_err, 1);

    run = 1'b1;
    capture("D", TOD_D, -1, -1, -1, 30);
    step();
    check("latch_busy", busy, 1);
    check("latch_valid", sym_valid, 0);
    load_tod(TOD_E);
    check("bypass_err", tod_err, 0);
    capture("E", TOD_E, -1, -1, 90, -1);

    load_tod(TOD_F);
    check("load_f_err", tod_err, 0);
    run = 1'b1;
    capture("F", TOD_F, -1, -1, -1, -1);
    capture("G", TOD_G, -1, -1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
